switch_conditioner: RTL and testbench

Input conditioner for the board slide switches, placed directly upstream of the data memory's memory-mapped switch read port at 0xC000_0000. It synchronizes the asynchronous raw switch levels into the processor clock domain and debounces each bit independently. It then presents a stable 10-bit vector to the data memory's `switches` input. Per-bit rise/fall pulses and a combined change pulse are also produced for a later interrupt or event-latch peripheral.

---
 rtl/switch_conditioner.sv | 70 +++++++
 tb/tb_switch_conditioner.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/switch_conditioner.sv
// Slide-switch input conditioner: two-flop synchronizer followed by an
// independent per-bit debounce counter, with registered rise/fall/change pulses.
module switch_conditioner #(
    parameter int N               = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    localparam int CW             = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] sw_raw,
    output logic [N-1:0] switches,
    output logic [N-1:0] sw_rise,
    output logic [N-1:0] sw_fall,
    output logic         sw_changed
);

    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]  r_sync1;
    logic [N-1:0]  r_sync2;
    logic [N-1:0]  r_switches;
    logic [N-1:0]  r_rise;
    logic [N-1:0]  r_fall;
    logic          r_changed;
    logic [CW-1:0] r_cnt [N];

    logic [N-1:0]  w_upd;

    // A bit is accepted on the edge its mismatch has persisted for the full window.
    always_comb begin
        w_upd = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_upd[i] = (r_sync2[i] != r_switches[i]) && (r_cnt[i] == LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_switches <= '0;
            r_rise     <= '0;
            r_fall     <= '0;
            r_changed  <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= sw_raw;
            r_sync2 <= r_sync1;
            for (int unsigned i = 0; i < N; i++) begin
                if (r_sync2[i] == r_switches[i] || w_upd[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
            r_switches <= r_switches ^ w_upd;
            r_rise     <= w_upd & r_sync2;
            r_fall     <= w_upd & ~r_sync2;
            r_changed  <= |w_upd;
        end
    end

    assign switches   = r_switches;
    assign sw_rise    = r_rise;
    assign sw_fall    = r_fall;
    assign sw_changed = r_changed;

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner: directed scenarios plus random bouncing,
// checked every cycle against a sliding-window reference model.
module tb_switch_conditioner;

    localparam int N = 10;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] sw_raw = '0;
    logic [N-1:0] switches;
    logic [N-1:0] sw_rise;
    logic [N-1:0] sw_fall;
    logic         sw_changed;

    int n_checks = 0;
    int n_errors = 0;

    switch_conditioner #(
        .N              (N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sw_raw    (sw_raw),
        .switches  (switches),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .sw_changed(sw_changed)
    );

    always #5 clk = ~clk;

    // Model: a level is accepted once the last D synchronized samples all
    // disagree with the currently accepted level.
    logic [N-1:0] m_s1 = '0;
    logic [N-1:0] m_s2 = '0;
    logic [N-1:0] m_sw = '0;
    logic [N-1:0] m_rise = '0;
    logic [N-1:0] m_fall = '0;
    logic         m_chg = 1'b0;
    logic [D-1:0] m_hist [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        logic [N-1:0] upd;
        @(posedge clk);
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_sw = '0;
            m_rise = '0; m_fall = '0; m_chg = 1'b0;
            for (int i = 0; i < N; i++) m_hist[i] = '0;
        end else begin
            upd = '0;
            for (int i = 0; i < N; i++) begin
                m_hist[i] = {m_hist[i][D-2:0], m_s2[i]};
                upd[i] = (m_hist[i] == {D{~m_sw[i]}});
            end
            m_rise = upd & m_s2;
            m_fall = upd & ~m_s2;
            m_chg  = |upd;
            m_sw   = m_sw ^ upd;
            m_s2   = m_s1;
            m_s1   = sw_raw;
        end
        #1;
        check("switches", 32'(switches), 32'(m_sw));
        check("sw_rise", 32'(sw_rise), 32'(m_rise));
        check("sw_fall", 32'(sw_fall), 32'(m_fall));
        check("sw_changed", 32'(sw_changed), 32'(m_chg));
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        for (int i = 0; i < N; i++) m_hist[i] = '0;

        // 1: reset with all switches high, then power-on rise events
        sw_raw = 10'h3FF;
        reset  = 1'b1;
        step();
        check("rst_switches", 32'(switches), 32'h0);
        check("rst_changed", 32'(sw_changed), 32'h0);
        step();
        reset = 1'b0;
        steps(5);
        check("por_before", 32'(switches), 32'h0);
        step();
        check("por_switches", 32'(switches), 32'h3FF);
        check("por_rise", 32'(sw_rise), 32'h3FF);
        check("por_changed", 32'(sw_changed), 32'h1);
        step();
        check("por_rise_clear", 32'(sw_rise), 32'h0);
        check("por_changed_clear", 32'(sw_changed), 32'h0);

        // 2: clean rising edge on bit 0
        sw_raw = '0;
        reset  = 1'b1;
        steps(2);
        reset  = 1'b0;
        steps(2);
        sw_raw = 10'h001;
        steps(5);
        check("clean_before", 32'(switches), 32'h000);
        step();
        check("clean_switches", 32'(switches), 32'h001);
        check("clean_rise", 32'(sw_rise), 32'h001);
        step();
        check("clean_rise_clear", 32'(sw_rise), 32'h000);

        // 3: bounce on bit 3, then settle high
        for (int k = 0; k < 4; k++) begin
            sw_raw[3] = (k % 2 == 0);
            for (int j = 0; j < 2; j++) begin
                step();
                check("bounce_hold", 32'(switches[3]), 32'h0);
            end
        end
        sw_raw[3] = 1'b1;
        steps(5);
        check("bounce_before", 32'(switches[3]), 32'h0);
        step();
        check("bounce_accept", 32'(switches[3]), 32'h1);
        check("bounce_rise", 32'(sw_rise), 32'h008);
        step();
        check("bounce_single", 32'(sw_rise), 32'h000);

        // 4: short glitch on bit 5
        sw_raw[5] = 1'b1;
        steps(3);
        sw_raw[5] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            check("glitch_changed", 32'(sw_changed), 32'h0);
            check("glitch_sw5", 32'(switches[5]), 32'h0);
        end

        // 5: simultaneous rise and fall
        sw_raw = 10'h00F;
        steps(8);
        check("simul_start", 32'(switches), 32'h00F);
        sw_raw = 10'h0F0;
        steps(6);
        check("simul_switches", 32'(switches), 32'h0F0);
        check("simul_rise", 32'(sw_rise), 32'h0F0);
        check("simul_fall", 32'(sw_fall), 32'h00F);
        check("simul_changed", 32'(sw_changed), 32'h1);
        step();
        check("simul_changed_clear", 32'(sw_changed), 32'h0);

        // 6: reset in the middle of a count
        sw_raw = '0;
        reset  = 1'b1;
        steps(2);
        reset  = 1'b0;
        steps(2);
        sw_raw = 10'h200;
        steps(3);
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            check("midrst_sw9", 32'(switches[9]), 32'h0);
            check("midrst_changed", 32'(sw_changed), 32'h0);
        end
        reset = 1'b0;
        steps(5);
        check("midrst_before", 32'(switches[9]), 32'h0);
        step();
        check("midrst_accept", 32'(switches[9]), 32'h1);
        check("midrst_rise", 32'(sw_rise), 32'h200);

        // Random bouncing with occasional resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0)
                sw_raw = sw_raw ^ N'($urandom_range(0, 1023) & $urandom_range(0, 1023));
            reset = ($urandom_range(0, 249) == 0);
            step();
        end
        reset = 1'b0;
        steps(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
